// File: rtl/joypad_debounce_array.sv
// N-channel joypad front end: synchroniser, counter debounce, press/release ticks, sticky events.
// Optional auto-fire gate on joypad_out is built when JOYPAD_TURBO_EN is defined.
module joypad_debounce_array #(
    parameter int CHANNELS   = 8,
    parameter int DEB_COUNT  = 2097151,
    parameter int ACTIVE_LOW = 0,
    parameter int TURBO_DIV  = 1048576
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] joypad,
    input  logic [CHANNELS-1:0] turbo_mask,
    input  logic [CHANNELS-1:0] evt_ack,
    output logic [CHANNELS-1:0] joypad_level,
    output logic [CHANNELS-1:0] joypad_out,
    output logic [CHANNELS-1:0] press_tick,
    output logic [CHANNELS-1:0] release_tick,
    output logic                btn_strobe,
    output logic [CHANNELS-1:0] evt_flags,
    output logic                evt_pending
);

    localparam int            CW       = $clog2(DEB_COUNT + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_COUNT - 1);

    logic [CHANNELS-1:0] pin_s;
    logic [CHANNELS-1:0] sync1_r;
    logic [CHANNELS-1:0] sync2_r;
    logic [CHANNELS-1:0] level_r;
    logic [CHANNELS-1:0] flip_s;
    logic [CHANNELS-1:0] press_r;
    logic [CHANNELS-1:0] release_r;
    logic [CHANNELS-1:0] flags_r;
    logic [CHANNELS-1:0] flags_nxt_s;
    logic                strobe_r;
    logic                pending_r;
    logic [CW-1:0]       cnt_r     [CHANNELS];
    logic [CW-1:0]       cnt_nxt_s [CHANNELS];

    assign pin_s = (ACTIVE_LOW != 0) ? ~joypad : joypad;

    // Two-flop synchroniser for the asynchronous pins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= {CHANNELS{1'b0}};
            sync2_r <= {CHANNELS{1'b0}};
        end else begin
            sync1_r <= pin_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-channel debounce count; the step that would reach DEB_COUNT flips the level instead
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt_s[i] = {CW{1'b0}};
            flip_s[i]    = 1'b0;
            if (sync2_r[i] != level_r[i]) begin
                if (cnt_r[i] == DEB_LAST) begin
                    flip_s[i] = 1'b1;
                end else begin
                    cnt_nxt_s[i] = cnt_r[i] + CW'(1'b1);
                end
            end else begin
                cnt_nxt_s[i] = {CW{1'b0}};
            end
        end
    end

    // Set beats ack when both hit the same bit in one cycle
    assign flags_nxt_s = (flags_r & ~evt_ack) | press_r;

    // Level, tick, and event-flag state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= {CW{1'b0}};
            end
            level_r   <= {CHANNELS{1'b0}};
            press_r   <= {CHANNELS{1'b0}};
            release_r <= {CHANNELS{1'b0}};
            strobe_r  <= 1'b0;
            flags_r   <= {CHANNELS{1'b0}};
            pending_r <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            level_r   <= level_r ^ flip_s;
            press_r   <= flip_s & ~level_r;
            release_r <= flip_s & level_r;
            strobe_r  <= |flip_s;
            flags_r   <= flags_nxt_s;
            pending_r <= |flags_nxt_s;
        end
    end

    assign joypad_level = level_r;
    assign press_tick   = press_r;
    assign release_tick = release_r;
    assign btn_strobe   = strobe_r;
    assign evt_flags    = flags_r;
    assign evt_pending  = pending_r;

`ifdef JOYPAD_TURBO_EN
    localparam int            TW         = $clog2(TURBO_DIV + 1);
    localparam logic [TW-1:0] TURBO_LAST = TW'(TURBO_DIV - 1);

    logic [TW-1:0]       turbo_cnt_r;
    logic                phase_r;
    logic [CHANNELS-1:0] out_r;

    // Free-running auto-fire phase and gated output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            turbo_cnt_r <= {TW{1'b0}};
            phase_r     <= 1'b1;
            out_r       <= {CHANNELS{1'b0}};
        end else begin
            if (turbo_cnt_r == TURBO_LAST) begin
                turbo_cnt_r <= {TW{1'b0}};
                phase_r     <= ~phase_r;
            end else begin
                turbo_cnt_r <= turbo_cnt_r + TW'(1'b1);
            end
            out_r <= level_r & (~turbo_mask | {CHANNELS{phase_r}});
        end
    end

    assign joypad_out = out_r;
`else
    logic unused_turbo_s;
    assign unused_turbo_s = ^turbo_mask;
    assign joypad_out     = level_r;
`endif

endmodule

// File: tb/tb_joypad_debounce_array.sv
// Scoreboard bench for joypad_debounce_array with DEB_COUNT=4, TURBO_DIV=3, CHANNELS=8.
module tb_joypad_debounce_array;

    typedef struct packed {
        logic [7:0] level;
        logic [7:0] press;
        logic [7:0] rel;
        logic       strobe;
        logic [7:0] flags;
        logic       pending;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] joypad, joypad_al, turbo_mask, evt_ack;
    logic [7:0] joypad_level, joypad_out, press_tick, release_tick, evt_flags;
    logic       btn_strobe, evt_pending;
    logic [7:0] level_al, out_al, press_al, release_al, flags_al;
    logic       strobe_al, pending_al;

    int   checks = 0;
    int   errors = 0;
    int   edges  = 0;
    obs_t exp_q[$];
    logic [15:0] out_q[$];

    joypad_debounce_array #(.CHANNELS(8), .DEB_COUNT(4), .ACTIVE_LOW(0), .TURBO_DIV(3)) dut (
        .clk(clk), .reset(reset), .joypad(joypad), .turbo_mask(turbo_mask), .evt_ack(evt_ack),
        .joypad_level(joypad_level), .joypad_out(joypad_out), .press_tick(press_tick),
        .release_tick(release_tick), .btn_strobe(btn_strobe), .evt_flags(evt_flags),
        .evt_pending(evt_pending)
    );

    joypad_debounce_array #(.CHANNELS(8), .DEB_COUNT(4), .ACTIVE_LOW(1), .TURBO_DIV(3)) dut_al (
        .clk(clk), .reset(reset), .joypad(joypad_al), .turbo_mask(8'h00), .evt_ack(8'h00),
        .joypad_level(level_al), .joypad_out(out_al), .press_tick(press_al),
        .release_tick(release_al), .btn_strobe(strobe_al), .evt_flags(flags_al),
        .evt_pending(pending_al)
    );

    // Clock edges since reset release, used to predict the turbo phase
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    function automatic obs_t snap(input logic [7:0] l, input logic [7:0] p, input logic [7:0] r,
                                  input logic s, input logic [7:0] f, input logic pd);
        return {l, p, r, s, f, pd};
    endfunction

    task automatic push_exp(input logic [7:0] lvl, input logic [7:0] prs, input logic [7:0] rls,
                            input logic [7:0] flg, input int n);
        obs_t e;
        e = '{level: lvl, press: prs, rel: rls, strobe: |(prs | rls), flags: flg, pending: |flg};
        repeat (n) exp_q.push_back(e);
    endtask

    task automatic test_reset();
        obs_t got, exp_v;
        reset = 1'b1; joypad = 8'h00; joypad_al = 8'hFF; turbo_mask = 8'h00; evt_ack = 8'h00;
        push_exp(8'h00, 8'h00, 8'h00, 8'h00, 1);
        repeat (3) @(negedge clk);
        got = snap(joypad_level, press_tick, release_tick, btn_strobe, evt_flags, evt_pending);
        exp_v = exp_q.pop_front();
        checks++;
        if (got !== exp_v) begin errors++; $display("FAIL reset_main: got %h, expected %h", got, exp_v); end
        got = snap(level_al, press_al, release_al, strobe_al, flags_al, pending_al);
        checks++;
        if (got !== 42'h0) begin errors++; $display("FAIL reset_al: got %h, expected 0", got); end
        checks++;
        if ({joypad_out, out_al} !== 16'h0000) begin
            errors++; $display("FAIL reset_out: got %h, expected 0000", {joypad_out, out_al});
        end
        reset = 1'b0;
    endtask

    task automatic test_clean_press();
        obs_t got, exp_v;
        joypad = 8'h01;
        push_exp(8'h00, 8'h00, 8'h00, 8'h00, 5);
        push_exp(8'h01, 8'h01, 8'h00, 8'h00, 1);
        push_exp(8'h01, 8'h00, 8'h00, 8'h01, 2);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            got = snap(joypad_level, press_tick, release_tick, btn_strobe, evt_flags, evt_pending);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL clean_press cycle %0d: got %h, expected %h", i, got, exp_v); end
        end
    endtask

    task automatic test_bounce();
        obs_t got, exp_v;
        logic [7:0] pat;
        pat = 8'b1111_0111;
        joypad[3] = pat[0];
        push_exp(8'h01, 8'h00, 8'h00, 8'h01, 9);
        push_exp(8'h09, 8'h08, 8'h00, 8'h01, 1);
        push_exp(8'h09, 8'h00, 8'h00, 8'h09, 2);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            got = snap(joypad_level, press_tick, release_tick, btn_strobe, evt_flags, evt_pending);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL bounce cycle %0d: got %h, expected %h", i, got, exp_v); end
            if (i < 8) joypad[3] = pat[i];
        end
    endtask

    task automatic test_ack_race();
        obs_t got, exp_v;
        joypad[0] = 1'b0;
        push_exp(8'h09, 8'h00, 8'h00, 8'h09, 5);
        push_exp(8'h08, 8'h00, 8'h01, 8'h09, 1);
        push_exp(8'h08, 8'h00, 8'h00, 8'h09, 5);
        push_exp(8'h09, 8'h01, 8'h00, 8'h09, 1);
        push_exp(8'h09, 8'h00, 8'h00, 8'h09, 2);
        push_exp(8'h09, 8'h00, 8'h00, 8'h00, 2);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            got = snap(joypad_level, press_tick, release_tick, btn_strobe, evt_flags, evt_pending);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL ack_race cycle %0d: got %h, expected %h", i, got, exp_v); end
            if (i == 2)  evt_ack = 8'h02;
            if (i == 3)  evt_ack = 8'h00;
            if (i == 6)  joypad[0] = 1'b1;
            if (i == 12) evt_ack = 8'h01;
            if (i == 13) evt_ack = 8'h00;
            if (i == 14) evt_ack = 8'h09;
            if (i == 15) evt_ack = 8'h00;
        end
    endtask

    task automatic test_multi_channel();
        obs_t got, exp_v;
        joypad = 8'h0B;
        push_exp(8'h09, 8'h00, 8'h00, 8'h00, 5);
        push_exp(8'h0B, 8'h02, 8'h00, 8'h00, 1);
        push_exp(8'h0B, 8'h00, 8'h00, 8'h02, 7);
        push_exp(8'h89, 8'h80, 8'h02, 8'h02, 1);
        push_exp(8'h89, 8'h00, 8'h00, 8'h82, 2);
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            got = snap(joypad_level, press_tick, release_tick, btn_strobe, evt_flags, evt_pending);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL multi_channel cycle %0d: got %h, expected %h", i, got, exp_v); end
            if (i == 8) joypad = 8'h89;
        end
    endtask

    task automatic test_active_low();
        obs_t got, exp_v;
        push_exp(8'h00, 8'h00, 8'h00, 8'h00, 8);
        push_exp(8'h01, 8'h01, 8'h00, 8'h00, 1);
        push_exp(8'h01, 8'h00, 8'h00, 8'h01, 2);
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            got = snap(level_al, press_al, release_al, strobe_al, flags_al, pending_al);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL active_low cycle %0d: got %h, expected %h", i, got, exp_v); end
            if (i == 3) joypad_al = 8'hFE;
        end
    endtask

    task automatic test_turbo();
        logic [15:0] got, exp_v;
        int e0;
        e0 = edges;
        turbo_mask = 8'h01;
        for (int i = 1; i <= 12; i++) begin
`ifdef JOYPAD_TURBO_EN
            out_q.push_back({8'h89, ((((e0 + i - 1) / 3) % 2) == 0) ? 8'h89 : 8'h88});
`else
            out_q.push_back({8'h89, 8'h89});
`endif
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            got = {joypad_level, joypad_out};
            exp_v = out_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL turbo cycle %0d: got %h, expected %h", i, got, exp_v); end
        end
        turbo_mask = 8'h00;
    endtask

    task automatic test_held_through_reset();
        obs_t got, exp_v;
        joypad = 8'h8B;
        push_exp(8'h89, 8'h00, 8'h00, 8'h82, 3);
        push_exp(8'h00, 8'h00, 8'h00, 8'h00, 6);
        push_exp(8'h8B, 8'h8B, 8'h00, 8'h00, 1);
        push_exp(8'h8B, 8'h00, 8'h00, 8'h8B, 2);
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            got = snap(joypad_level, press_tick, release_tick, btn_strobe, evt_flags, evt_pending);
            exp_v = exp_q.pop_front();
            checks++;
            if (got !== exp_v) begin errors++; $display("FAIL held_reset cycle %0d: got %h, expected %h", i, got, exp_v); end
            if (i == 3) reset = 1'b1;
            if (i == 4) reset = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_ack_race();
        test_multi_channel();
        test_active_low();
        test_turbo();
        test_held_through_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/joypad_debounce_array.md
# joypad_debounce_array

Parametrised debouncer and event capture for N push-button channels, the next generation of the fixed 8-button joypad front end. Each channel is synchronised, counter-debounced, and produces a stable level plus one-cycle press/release ticks. A sticky per-channel event register with acknowledge lets the NES controller-port logic or a soft CPU collect presses without polling every cycle. An optional turbo (auto-fire) stage gates selected channels with a square wave before they reach the NES shift register.

## Interface
Parameters:
- `CHANNELS`, 8: number of button channels; bit 0 = A, 1 = B, 2 = SELECT, 3 = START, 4 = UP, 5 = DOWN, 6 = LEFT, 7 = RIGHT.
- `DEB_COUNT`, 2097151: consecutive stable cycles required to accept a change; must be ≥ 2.
- `ACTIVE_LOW`, 0: 1 inverts the raw pins before synchronisation.
- `TURBO_DIV`, 1048576: cycles per turbo half-period; must be ≥ 1.

Ports:
- `clk  in  1`: system clock; single clock domain.
- `reset  in  1`: asynchronous, active-high reset.
- `joypad  in  CHANNELS`: raw button pins, asynchronous.
- `turbo_mask  in  CHANNELS`: 1 = apply turbo to the channel.
- `evt_ack  in  CHANNELS`: 1-cycle pulse per bit; clears the matching `evt_flags` bit.
- `joypad_level  out  CHANNELS`: debounced level, active-high pressed.
- `joypad_out  out  CHANNELS`: level after the turbo gate; this bus feeds the NES.
- `press_tick  out  CHANNELS`: 1-cycle pulse on an accepted 0→1 transition.
- `release_tick  out  CHANNELS`: 1-cycle pulse on an accepted 1→0 transition.
- `btn_strobe  out  1`: OR of all press and release ticks.
- `evt_flags  out  CHANNELS`: sticky press flags.
- `evt_pending  out  1`: OR-reduction of `evt_flags`.

## Operation
- **Per-channel input path:** XOR the pin with `ACTIVE_LOW`, then pass it through a 2-FF synchroniser.
- **Debounce counter:** width is $clog2(DEB_COUNT+1).
  - When sync output ≠ level: counter increments.
  - When sync output = level: counter clears to 0.
  - When the counter would reach DEB_COUNT: the level flips, the counter clears, and the matching tick pulses.
- **Glitch rejection:** a glitch shorter than DEB_COUNT cycles restarts the count and never changes the level.
- **Registered outputs:** `press_tick`, `release_tick` and `btn_strobe` are registered and assert in the same cycle the new level first appears.
- **Event flags:**
  - Set on `press_tick`; cleared on `evt_ack`.
  - Set and ack on the same bit in the same cycle: set wins.
  - Release does not clear a flag.
- **Turbo:** when compiled in, see Configuration. When compiled out, `joypad_out` = `joypad_level`.
- **No-op cases:**
  - `evt_ack` on a bit that is already clear has no effect.
  - `turbo_mask` changes take effect on the next cycle.

## Timing
- **Reset values:** all outputs 0; counters 0; synchronisers 0; turbo phase 1.
- **Pin-to-level latency:** a pin change that is stable before edge k appears on `joypad_level` after edge k+1+DEB_COUNT, i.e. DEB_COUNT+2 cycles.
- **Tick timing:** ticks are high for exactly one cycle, coincident with the level change.
- **Flag timing:** an `evt_flags` bit is visible one cycle after its `press_tick`. `evt_pending` is registered and follows `evt_flags` in the same cycle.
- **Simultaneous channels:** several channels may tick in the same cycle. `btn_strobe` still pulses for one cycle only.
- **Reset mid-count:** partial counts are discarded, no tick is emitted, and flags are lost.
- **Held button:** a button held through reset release is re-accepted DEB_COUNT+2 cycles after reset deasserts and produces a `press_tick`.

## Configuration
- Macro: `JOYPAD_TURBO_EN`.
- **Defined:**
  - A free-running counter toggles the turbo phase every TURBO_DIV cycles; phase resets to 1.
  - `joypad_out[i]` = `joypad_level[i]` & (~`turbo_mask[i]` | phase), registered, so it lags `joypad_level` by 1 cycle.
- **Undefined:**
  - No turbo counter is built.
  - `turbo_mask` is ignored.
  - `joypad_out` is a combinational copy of `joypad_level`.

## Test plan
All scenarios use DEB_COUNT=4, TURBO_DIV=3, CHANNELS=8.
- **Clean press:** raise `joypad[0]` and hold → `joypad_level[0]`=1 at cycle +6; `press_tick[0]` and `btn_strobe` high for that single cycle; `evt_flags`=8'h01 and `evt_pending`=1 the next cycle.
- **Bounce:** toggle `joypad[3]` 1,1,1,0,1,1,1,1 → level rises only after the final 4-cycle stable run; exactly one `press_tick[3]`.
- **Ack race:** hold `evt_flags[0]`=1, then pulse `evt_ack[0]` in the same cycle as a new `press_tick[0]` → flag remains 1. A later ack alone → flag 0, `evt_pending` 0.
- **Multi-channel:** release ch 1 and press ch 7 on the same cycle → `release_tick`=8'h02, `press_tick`=8'h80, one `btn_strobe` pulse.
- **ACTIVE_LOW=1:** drive `joypad`=8'hFF → all levels stay 0. Drive 8'hFE → `joypad_level`=8'h01 after 6 cycles.
- **Turbo:** with `JOYPAD_TURBO_EN`, hold ch 0 with `turbo_mask`=8'h01 → `joypad_out[0]` alternates 3 cycles high, 3 cycles low while `joypad_level[0]` stays 1. Without the macro → `joypad_out[0]` stays 1.
